// File: rtl/curve_lut_pkg.sv
// curve_lut_pkg: shared helpers and types for the shared tone-curve lookup
package curve_lut_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int NREQ_MAX = 8;
  typedef logic [clog2_min1(NREQ_MAX)-1:0] req_id_t;
  function automatic longint clamp_idx(input longint value, input longint depth);
    return (value < 0) ? 0 : (value > depth - 1) ? depth - 1 : value;
  endfunction
endpackage

// File: rtl/curve_lut_rr_arbiter.sv
// curve_lut_rr_arbiter: round-robin grant over N requesters; pointer moves past each winner
module curve_lut_rr_arbiter
  import curve_lut_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_lane;
  logic          w_found;
  always_comb begin
    w_found = 1'b0;
    o_gnt_idx = '0;
    w_lane = '0;
    for (int k = 0; k < N; k++) begin
      w_lane = IW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_lane]) begin
        w_found = 1'b1;
        o_gnt_idx = w_lane;
      end
    end
  end
  assign o_gnt = (i_en && w_found) ? N'(1) << o_gnt_idx : '0;
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (|o_gnt) r_ptr <= (int'(o_gnt_idx) == N - 1) ? '0 : o_gnt_idx + 1'b1;
  end
endmodule

// File: rtl/curve_lut_arbiter.sv
// curve_lut_arbiter: one tone-curve table shared round-robin by NREQ lanes, clamped index, tagged response.
// Define CURVE_LUT_WRITE_EN to add a cfg write port; otherwise the table is a ROM holding INIT.
module curve_lut_arbiter
  import curve_lut_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 255,
  parameter logic [DEPTH*WIDTH-1:0] INIT = '0,
  localparam int IW = clog2_min1(NREQ),
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IW-1:0]         rsp_id,
  input  logic                  rsp_ready
`ifdef CURVE_LUT_WRITE_EN
  ,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [WIDTH-1:0]      cfg_wdata
`endif
);
  logic             w_can_issue;
  logic             w_block;
  logic             w_grant;
  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_rd_data;
  logic [AW-1:0]    w_idx;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IW-1:0]    r_rsp_id;
`ifdef CURVE_LUT_WRITE_EN
  logic [DEPTH*WIDTH-1:0] r_mem = INIT;
  assign w_block = cfg_we;
  always_ff @(posedge clk) begin
    if (cfg_we && int'(cfg_addr) < DEPTH) r_mem[int'(cfg_addr)*WIDTH +: WIDTH] <= cfg_wdata;
  end
  assign w_rd_data = r_mem[int'(w_idx)*WIDTH +: WIDTH];
`else
  assign w_block = 1'b0;
  assign w_rd_data = INIT[int'(w_idx)*WIDTH +: WIDTH];
`endif
  assign w_can_issue = !r_rsp_valid || rsp_ready;
  curve_lut_rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_en      (w_can_issue && !w_block && !rst),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );
  assign req_ready = w_gnt;
  assign w_grant = |w_gnt;
  assign w_sel_data = req_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
  // sign-extend at full width before clamping so large negatives never wrap into range
  assign w_idx = AW'(clamp_idx(longint'($signed(w_sel_data)), longint'(DEPTH)));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id <= '0;
    end else begin
      if (w_can_issue) r_rsp_valid <= w_grant;
      if (w_grant) begin
        r_rsp_data <= w_rd_data;
        r_rsp_id <= w_gnt_idx;
      end
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign rsp_id = r_rsp_id;
endmodule
